pc_fetch_sequencer: RTL and testbench

Multi-cycle replacement for the single-cycle PC update path. It owns the 64-bit program counter and issues instruction-memory fetches over a req/ack handshake. It holds each instruction for the datapath until the datapath signals completion, then computes the next PC from branch/jump/jalr control. It sits between instruction memory, the control unit/ALU, and the immediate generator.

---
 rtl/pc_fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle PC owner: fetches each instruction over a req/ack handshake,
// holds it for the datapath, then advances the PC from branch/jump/jalr control.
module pc_fetch_sequencer #(
    parameter int                XLEN     = 64,
    parameter logic [XLEN-1:0]   RESET_PC = {XLEN{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    input  logic              jalr,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   jalr_target,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic              misaligned
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_instr;
    logic              r_instr_valid;
    logic              r_misaligned;

    state_t            w_state_next;
    logic [XLEN-1:0]   w_pc_next;
    logic [31:0]       w_instr_next;
    logic              w_instr_valid_next;
    logic              w_misaligned_next;

    logic [XLEN-1:0]   w_jalr_pc;
    logic [XLEN-1:0]   w_rel_pc;
    logic [XLEN-1:0]   w_seq_pc;
    logic [XLEN-1:0]   w_target;

    // jalr clears bit 0 only; bit 1 surviving is what raises the misalignment trap.
    assign w_jalr_pc = jalr_target & ~{{(XLEN-1){1'b0}}, 1'b1};
    assign w_rel_pc  = r_pc + (imm << 1);
    assign w_seq_pc  = r_pc + {{(XLEN-3){1'b0}}, 3'd4};

    always_comb begin
        w_target = w_seq_pc;
        if (jalr) begin
            w_target = w_jalr_pc;
        end else if (jump || (branch && zero)) begin
            w_target = w_rel_pc;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_instr_next       = r_instr;
        w_instr_valid_next = r_instr_valid;
        w_misaligned_next  = r_misaligned;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_instr_next       = imem_rdata;
                    w_instr_valid_next = 1'b1;
                    w_state_next       = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    w_instr_valid_next = 1'b0;
                    if (w_target[1:0] != 2'b00) begin
                        w_misaligned_next = 1'b1;
                        w_state_next      = S_TRAP;
                    end else begin
                        w_pc_next    = w_target;
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_TRAP: begin
                w_instr_valid_next = 1'b0;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_instr       <= w_instr_next;
            r_instr_valid <= w_instr_valid_next;
            r_misaligned  <= w_misaligned_next;
        end
    end

    // The request is a pure function of state, so it drops on the edge that leaves FETCH.
    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_seq_pc;
    assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench for pc_fetch_sequencer: sequential fetch, branch,
// jump, jalr, wrap-around, misalignment trap and reset during an outstanding fetch.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;
    logic        jalr = 1'b0;
    logic [63:0] imm = 64'h0;
    logic [63:0] jalr_target = 64'h0;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        misaligned;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .exec_done(exec_done), .branch(branch), .zero(zero),
        .jump(jump), .jalr(jalr), .imm(imm), .jalr_target(jalr_target),
        .pc(pc), .pc_plus4(pc_plus4), .misaligned(misaligned)
    );

    // Stimulus only: waits (bounded) for a request, answers it after lat cycles.
    task automatic do_fetch(input logic [31:0] word, input int lat,
                            output logic [63:0] addr, output logic stable);
        int waited = 0;
        stable = 1'b1;
        addr   = 64'h0;
        while (imem_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (imem_req !== 1'b1) begin
            n_assert++;
            n_fail++;
            $display("FAIL fetch_timeout: imem_req=%b required 1 within 20 cycles", imem_req);
            return;
        end
        addr = imem_addr;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            if (imem_req !== 1'b1 || imem_addr !== addr) stable = 1'b0;
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        $display("fetch addr=%h instr=%h", addr, word);
    endtask

    task automatic do_exec(input logic br, input logic z, input logic jp, input logic jr,
                           input logic [63:0] im, input logic [63:0] jt);
        @(negedge clk);
        branch = br; zero = z; jump = jp; jalr = jr; imm = im; jalr_target = jt;
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        branch = 1'b0; zero = 1'b0; jump = 1'b0; jalr = 1'b0;
        imm = 64'h0; jalr_target = 64'h0;
    endtask

    task automatic set_pc(input logic [63:0] target);
        logic [63:0] a;
        logic        s;
        do_fetch(32'h0000_0013, 1, a, s);
        do_exec(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, target);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_assert++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b required 0", imem_req); end
        n_assert++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", instr_valid); end
        n_assert++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h required 0", instr); end
        n_assert++; if (pc !== 64'h0) begin n_fail++; $display("FAIL reset_pc: got %h required 0", pc); end
        n_assert++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b required 0", misaligned); end
        reset = 1'b0;
        @(negedge clk);
        n_assert++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b required 1", imem_req); end
        n_assert++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL first_addr: got %h required 0", imem_addr); end
        n_assert++; if (pc_plus4 !== 64'h4) begin n_fail++; $display("FAIL first_plus4: got %h required 4", pc_plus4); end
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        logic [63:0] a;
        logic [63:0] exp_pc;
        logic        s;
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        words[2] = 32'h0020_0113;
        for (int k = 0; k < 3; k++) begin
            exp_pc = 64'(k) * 64'd4;
            do_fetch(words[k], 2, a, s);
            n_assert++; if (a !== exp_pc) begin n_fail++; $display("FAIL seq_addr%0d: got %h required %h", k, a, exp_pc); end
            n_assert++; if (s !== 1'b1) begin n_fail++; $display("FAIL seq_stable%0d: got %b required 1", k, s); end
            n_assert++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d: got %b required 1", k, instr_valid); end
            n_assert++; if (instr !== words[k]) begin n_fail++; $display("FAIL seq_instr%0d: got %h required %h", k, instr, words[k]); end
            n_assert++; if (pc !== exp_pc) begin n_fail++; $display("FAIL seq_pc%0d: got %h required %h", k, pc, exp_pc); end
            n_assert++; if (pc_plus4 !== exp_pc + 64'd4) begin n_fail++; $display("FAIL seq_plus4%0d: got %h required %h", k, pc_plus4, exp_pc + 64'd4); end
            n_assert++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_req_exec%0d: got %b required 0", k, imem_req); end
            do_exec(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        end
    endtask

    task automatic test_branch();
        logic [63:0] a;
        logic        s;
        set_pc(64'h10);
        do_fetch(32'h0000_0463, 1, a, s);
        n_assert++; if (a !== 64'h10) begin n_fail++; $display("FAIL br_start: got %h required 10", a); end
        do_exec(1'b1, 1'b1, 1'b0, 1'b0, 64'h8, 64'h0);
        do_fetch(32'h0000_0013, 1, a, s);
        n_assert++; if (a !== 64'h20) begin n_fail++; $display("FAIL br_taken: got %h required 20", a); end
        do_exec(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        set_pc(64'h10);
        do_fetch(32'h0000_0463, 1, a, s);
        do_exec(1'b1, 1'b0, 1'b0, 1'b0, 64'h8, 64'h0);
        do_fetch(32'h0000_0013, 1, a, s);
        n_assert++; if (a !== 64'h14) begin n_fail++; $display("FAIL br_not_taken: got %h required 14", a); end
        do_exec(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic test_jump();
        logic [63:0] a;
        logic        s;
        set_pc(64'h40);
        do_fetch(32'h0000_006F, 1, a, s);
        n_assert++; if (a !== 64'h40) begin n_fail++; $display("FAIL jmp_start: got %h required 40", a); end
        do_exec(1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0);
        do_fetch(32'h0000_0067, 1, a, s);
        n_assert++; if (a !== 64'h20) begin n_fail++; $display("FAIL jmp_neg: got %h required 20", a); end
        // jalr must beat jump; the jump target here would be 0x220.
        do_exec(1'b1, 1'b1, 1'b1, 1'b1, 64'h100, 64'h101);
        do_fetch(32'h0000_0013, 1, a, s);
        n_assert++; if (a !== 64'h100) begin n_fail++; $display("FAIL jalr_lsb: got %h required 100", a); end
        do_exec(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic test_wrap();
        logic [63:0] a;
        logic        s;
        set_pc(64'hFFFF_FFFF_FFFF_FFFC);
        do_fetch(32'h0000_0013, 1, a, s);
        n_assert++; if (a !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_start: got %h required fffffffffffffffc", a); end
        n_assert++; if (pc_plus4 !== 64'h0) begin n_fail++; $display("FAIL wrap_plus4: got %h required 0", pc_plus4); end
        do_exec(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        do_fetch(32'h0000_0013, 1, a, s);
        n_assert++; if (a !== 64'h0) begin n_fail++; $display("FAIL wrap_next: got %h required 0", a); end
        do_exec(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic test_misaligned();
        logic [63:0] a;
        logic        s;
        set_pc(64'h80);
        do_fetch(32'h0000_0067, 1, a, s);
        n_assert++; if (a !== 64'h80) begin n_fail++; $display("FAIL mis_start: got %h required 80", a); end
        do_exec(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h102);
        n_assert++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b required 1", misaligned); end
        n_assert++; if (pc !== 64'h80) begin n_fail++; $display("FAIL mis_pc: got %h required 80", pc); end
        n_assert++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid: got %b required 0", instr_valid); end
        for (int c = 0; c < 12; c++) begin
            exec_done = 1'b1; jalr = 1'b1; jalr_target = 64'h200;
            imem_ack = c[0]; imem_rdata = 32'hCAFE_F00D;
            @(negedge clk);
            n_assert++; if (imem_req !== 1'b0 || pc !== 64'h80) begin n_fail++; $display("FAIL trap_hold%0d: req=%b pc=%h required req=0 pc=80", c, imem_req, pc); end
        end
        exec_done = 1'b0; jalr = 1'b0; jalr_target = 64'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        @(negedge clk);
        n_assert++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL trap_sticky: got %b required 1", misaligned); end
        n_assert++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL trap_valid: got %b required 0", instr_valid); end
    endtask

    task automatic test_reset_in_fetch();
        reset = 1'b1;
        @(negedge clk);
        n_assert++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_clears_mis: got %b required 0", misaligned); end
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_assert++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rf_outstanding: got %b required 1", imem_req); end
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_assert++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rf_req_drop: got %b required 0", imem_req); end
        n_assert++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rf_valid: got %b required 0", instr_valid); end
        @(negedge clk);
        n_assert++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rf_stray_ack: got %h required 0", instr); end
        // The ack stays high across the IDLE cycle after release and must still be ignored.
        reset = 1'b0;
        @(negedge clk);
        n_assert++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rf_first_req: got %b required 1", imem_req); end
        n_assert++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL rf_addr: got %h required 0", imem_addr); end
        n_assert++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL rf_late_ack: valid=%b instr=%h required 0/0", instr_valid, instr); end
        n_assert++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL rf_mis: got %b required 0", misaligned); end
        imem_ack = 1'b0; imem_rdata = 32'h0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_wrap();
        test_misaligned();
        test_reset_in_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
